// File: rtl/phase_comp_ctrl_rr_if.sv
// Signal bundle for phase_comp_ctrl_rr: PD inputs, update gating, register port and outputs.
interface phase_comp_ctrl_rr_if #(
  parameter int unsigned NCH = 16,
  parameter int unsigned W   = 10,
  parameter int unsigned OW  = 6,
  parameter int unsigned SHW = 3
);
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic              enable;
  logic              en_mid;
  logic [NCH-1:0]    freeze;
  logic [NCH-1:0]    pd_in;
  logic [SHW-1:0]    step_sh;
  logic [CW-1:0]     reg_num;
  logic              reg_write;
  logic [W-1:0]      reg_load_data;
  logic [W-1:0]      reg_read_data;
  logic [NCH*OW-1:0] ctrl_out;
  logic [NCH-1:0]    lock;

  modport master (
    output enable, en_mid, freeze, pd_in, step_sh, reg_num, reg_write, reg_load_data,
    input  reg_read_data, ctrl_out, lock
  );

  modport slave (
    input  enable, en_mid, freeze, pd_in, step_sh, reg_num, reg_write, reg_load_data,
    output reg_read_data, ctrl_out, lock
  );
endinterface

// File: rtl/phase_comp_ctrl_rr.sv
// Round-robin phase-compensator controller: one shared saturating step datapath over NCH accumulators.
// Optional 2-of-2 PD agreement filter enabled by defining PHASE_COMP_PD_FILT_EN.
module phase_comp_ctrl_rr #(
  parameter int unsigned NCH     = 16,
  parameter int unsigned W       = 10,
  parameter int unsigned OW      = 6,
  parameter int unsigned SHW     = 3,
  parameter int unsigned MID_CH  = 7,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter int unsigned LOCK_N  = 4
) (
  input logic                 clk,
  input logic                 reset,
  phase_comp_ctrl_rr_if.slave bus
);
  localparam int unsigned   CW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [3:0]    LockN  = 4'(LOCK_N);
  localparam logic [CW-1:0] LastCh = CW'(NCH - 1);

  logic [NCH-1:0] pd_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   acc_q  [NCH];
  logic [W-1:0]   acc_d  [NCH];
  logic [3:0]     tcnt_q [NCH];
  logic [3:0]     tcnt_d [NCH];
  logic [NCH-1:0] last_q, last_d;
  logic [NCH-1:0] lock_q, lock_d;
  logic [NCH-1:0] wr_sel, elig, upd;
`ifdef PHASE_COMP_PD_FILT_EN
  logic [NCH-1:0] filt_q, filt_d;
`endif

  logic         wr_hit;
  logic         dir;
  logic         big;
  logic [W-1:0] acc_sel, step_res;
  logic [W:0]   step, sum, diff;

  assign wr_hit = bus.reg_write && (32'(bus.reg_num) < NCH);

  // Shared datapath for the visited channel; W+1 bits expose carry/borrow for clamping.
  always_comb begin
    acc_sel = acc_q[cnt_q];
    dir     = pd_q[cnt_q];
    big     = 32'(bus.step_sh) > W;
    step    = {{W{1'b0}}, 1'b1} << bus.step_sh;
    sum     = {1'b0, acc_sel} + step;
    diff    = {1'b0, acc_sel} - step;
    if (dir) step_res = (big || diff[W]) ? '0 : diff[W-1:0];
    else     step_res = (big || sum[W])  ? '1 : sum[W-1:0];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.enable) cnt_d = (cnt_q == LastCh) ? '0 : cnt_q + 1'b1;
    last_d = last_q;
    lock_d = lock_q;
`ifdef PHASE_COMP_PD_FILT_EN
    filt_d = filt_q;
`endif
    for (int unsigned k = 0; k < NCH; k++) begin
      acc_d[k]  = acc_q[k];
      tcnt_d[k] = tcnt_q[k];
      wr_sel[k] = wr_hit && (bus.reg_num == CW'(k));
      elig[k]   = bus.enable && (cnt_q == CW'(k)) && !bus.freeze[k] &&
                  ((k != MID_CH) || bus.en_mid) && !wr_sel[k];
`ifdef PHASE_COMP_PD_FILT_EN
      // Only move when this visit's PD agrees with the previous visit's.
      upd[k] = elig[k] && (pd_q[k] == filt_q[k]);
      if (elig[k]) filt_d[k] = pd_q[k];
`else
      upd[k] = elig[k];
`endif
      if (upd[k]) begin
        acc_d[k]  = step_res;
        last_d[k] = dir;
        if (dir != last_q[k]) tcnt_d[k] = (tcnt_q[k] == LockN) ? LockN : tcnt_q[k] + 4'd1;
        else                  tcnt_d[k] = '0;
        lock_d[k] = (tcnt_d[k] == LockN);
      end
      if (wr_sel[k]) begin
        acc_d[k]  = bus.reg_load_data;
        tcnt_d[k] = '0;
        lock_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
      lock_q <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        acc_q[k]  <= RST_VAL;
        tcnt_q[k] <= '0;
      end
    end else begin
      pd_q   <= bus.pd_in;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      lock_q <= lock_d;
      for (int unsigned k = 0; k < NCH; k++) begin
        acc_q[k]  <= acc_d[k];
        tcnt_q[k] <= tcnt_d[k];
      end
    end
  end

`ifdef PHASE_COMP_PD_FILT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) filt_q <= '0;
    else       filt_q <= filt_d;
  end
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_out
    assign bus.ctrl_out[k*OW +: OW] = acc_q[k][W-1 -: OW];
  end

  assign bus.lock = lock_q;

  always_comb begin
    bus.reg_read_data = '0;
    if (32'(bus.reg_num) < NCH) bus.reg_read_data = acc_q[bus.reg_num];
  end
endmodule

// File: tb/tb_phase_comp_ctrl_rr.sv
// Directed bench for phase_comp_ctrl_rr: NCH=16 and NCH=5 instances, queue-based expectations.
module tb_phase_comp_ctrl_rr;
  localparam int KAcc  = 0;
  localparam int KAcc5 = 1;
  localparam int KLock = 2;
  localparam int KCtrl = 3;

  typedef struct {
    int          kind;
    int          ch;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sbq[$];
  int   pat[10] = '{1, 0, 1, 0, 1, 1, 0, 1, 0, 1};

  always #10 clk = ~clk;

  phase_comp_ctrl_rr_if #(.NCH(16), .W(10), .OW(6), .SHW(3)) bus ();
  phase_comp_ctrl_rr_if #(.NCH(5), .W(10), .OW(6), .SHW(3)) bus5 ();

  phase_comp_ctrl_rr #(
    .NCH(16), .W(10), .OW(6), .SHW(3), .MID_CH(7), .RST_VAL(10'd0), .LOCK_N(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  phase_comp_ctrl_rr #(
    .NCH(5), .W(10), .OW(6), .SHW(3), .MID_CH(7), .RST_VAL(10'd0), .LOCK_N(4)
  ) dut5 (
    .clk(clk), .reset(reset), .bus(bus5)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void push(input int kind, input int ch, input logic [31:0] v,
                               input string tag);
    exp_t e;
    e.kind = kind;
    e.ch   = ch;
    e.exp  = v;
    e.tag  = tag;
    sbq.push_back(e);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Pops every pending expectation; sync spaces reads one per cycle (enables must be low).
  task automatic drain(input bit sync);
    exp_t        e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (sync) @(negedge clk);
      case (e.kind)
        KAcc:  begin bus.reg_num  = 4'(e.ch); #1 obs = 32'(bus.reg_read_data);  end
        KAcc5: begin bus5.reg_num = 3'(e.ch); #1 obs = 32'(bus5.reg_read_data); end
        KLock: begin #1 obs = 32'(bus.lock); end
        default: begin #1 obs = 32'(bus.ctrl_out[e.ch*6 +: 6]); end
      endcase
      check(e.tag, obs, e.exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;  bus.en_mid = 1'b1;  bus.freeze = '0;  bus.pd_in = '0;
    bus.step_sh = '0;   bus.reg_num = '0;   bus.reg_write = 1'b0;  bus.reg_load_data = '0;
    bus5.enable = 1'b0; bus5.en_mid = 1'b1; bus5.freeze = '0; bus5.pd_in = '0;
    bus5.step_sh = '0;  bus5.reg_num = '0;  bus5.reg_write = 1'b0; bus5.reg_load_data = '0;

    @(negedge clk);
    push(KCtrl, 0, 32'h0, "rst_ctrl0");
    push(KLock, 0, 32'h0, "rst_lock");
    push(KAcc, 3, 32'h0, "rst_acc3");
    drain(1'b0);
    reset = 1'b0;

    // Two full sweeps, all up by 1.
    bus.enable = 1'b1;
    tick(32);
    bus.enable = 1'b0;
    for (int k = 0; k < 16; k++) push(KAcc, k, 32'd2, $sformatf("sweep_acc%0d", k));
    push(KCtrl, 3, 32'h0, "sweep_ctrl3");
    drain(1'b1);

    // Saturation on ch5.
    bus.reg_num = 4'd5; bus.reg_load_data = 10'h3FE; bus.reg_write = 1'b1;
    tick(1);
    bus.reg_write = 1'b0;
    push(KAcc, 5, 32'h3FE, "wr_acc5");
    drain(1'b1);
    bus.step_sh = 3'd2; bus.enable = 1'b1;
    tick(6);
    bus.enable = 1'b0;
    push(KAcc, 5, 32'h3FF, "sat_hi_acc5");
    push(KAcc, 0, 32'd6, "step4_acc0");
    push(KAcc, 6, 32'd2, "unvisited_acc6");
    drain(1'b1);
    bus.enable = 1'b1;
    tick(16);
    bus.enable = 1'b0;
    push(KAcc, 5, 32'h3FF, "sat_hold_acc5");
    push(KCtrl, 5, 32'h3F, "sat_ctrl5");
    drain(1'b1);
    bus.pd_in[5] = 1'b1; bus.enable = 1'b1;
    tick(16);
    bus.enable = 1'b0;
    push(KAcc, 5, 32'h3FB, "down_acc5");
    push(KAcc, 6, 32'd10, "up_acc6");
    drain(1'b1);
    bus.pd_in = '0;

    // Freeze ch2 and gate the mid channel for three sweeps.
    push(KAcc, 2, 32'd14, "frozen_acc2");
    push(KAcc, 7, 32'd10, "mid_gated_acc7");
    push(KAcc, 0, 32'd17, "free_acc0");
    push(KAcc, 10, 32'd13, "free_acc10");
    push(KAcc, 5, 32'h3FE, "free_acc5");
    bus.step_sh = '0; bus.freeze = 16'h0004; bus.en_mid = 1'b0; bus.enable = 1'b1;
    tick(48);
    bus.enable = 1'b0; bus.freeze = '0; bus.en_mid = 1'b1;
    drain(1'b1);

    // Write collides with the visit of ch4; counter must still advance.
    bus.enable = 1'b1;
    tick(14);
    bus.reg_num = 4'd4; bus.reg_load_data = 10'h155; bus.reg_write = 1'b1;
    tick(1);
    bus.reg_write = 1'b0;
    tick(1);
    bus.enable = 1'b0;
    push(KAcc, 4, 32'h155, "wr_wins_acc4");
    push(KAcc, 5, 32'h3FF, "cnt_adv_acc5");
    push(KAcc, 6, 32'd14, "cnt_adv_acc6");
    drain(1'b1);

    // Lock on ch9 from alternating PD directions, one visit per sweep.
    for (int i = 0; i < 10; i++) begin
      bus.pd_in[9] = (pat[i] != 0);
      bus.enable = 1'b1;
      tick(16);
      bus.enable = 1'b0;
      if (i == 2) push(KLock, 0, 32'h0, "lock_after3");
      if (i == 4) push(KLock, 0, 32'h200, "lock_after5");
      if (i == 5) push(KLock, 0, 32'h0, "lock_cleared");
      if (i == 9) push(KLock, 0, 32'h200, "lock_again");
      drain(1'b1);
    end
    bus.pd_in = '0;

    // NCH=5: enable held low mid-sweep, wrap, out-of-range register port.
    bus5.enable = 1'b1;
    tick(2);
    bus5.enable = 1'b0;
    tick(3);
    bus5.enable = 1'b1;
    tick(4);
    bus5.enable = 1'b0;
    push(KAcc5, 0, 32'd2, "n5_acc0");
    for (int k = 1; k < 5; k++) push(KAcc5, k, 32'd1, $sformatf("n5_acc%0d", k));
    push(KAcc5, 5, 32'd0, "n5_rd_oob5");
    push(KAcc5, 7, 32'd0, "n5_rd_oob7");
    drain(1'b1);
    bus5.reg_num = 3'd6; bus5.reg_load_data = 10'h3FF; bus5.reg_write = 1'b1;
    tick(1);
    bus5.reg_write = 1'b0;
    push(KAcc5, 0, 32'd2, "n5_oobwr_acc0");
    for (int k = 1; k < 5; k++) push(KAcc5, k, 32'd1, $sformatf("n5_oobwr_acc%0d", k));
    drain(1'b1);
    bus5.enable = 1'b1;
    tick(1);
    bus5.enable = 1'b0;
    push(KAcc5, 1, 32'd2, "n5_wrap_acc1");
    push(KAcc5, 2, 32'd1, "n5_wrap_acc2");
    drain(1'b1);

    // Asynchronous reset between clock edges.
    bus.enable = 1'b1; bus5.enable = 1'b1;
    tick(2);
    bus.enable = 1'b0; bus5.enable = 1'b0;
    push(KAcc5, 2, 32'd2, "pre_rst_n5_acc2");
    push(KCtrl, 5, 32'h3F, "pre_rst_ctrl5");
    drain(1'b0);
    #1 reset = 1'b1;
    push(KLock, 0, 32'h0, "async_rst_lock");
    push(KCtrl, 5, 32'h0, "async_rst_ctrl5");
    push(KAcc5, 2, 32'd0, "async_rst_n5_acc2");
    drain(1'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.enable = 1'b1; bus5.enable = 1'b1;
    tick(1);
    bus.enable = 1'b0; bus5.enable = 1'b0;
    push(KAcc, 0, 32'd1, "post_rst_acc0");
    push(KAcc, 1, 32'd0, "post_rst_acc1");
    push(KAcc5, 0, 32'd1, "post_rst_n5_acc0");
    push(KAcc5, 1, 32'd0, "post_rst_n5_acc1");
    drain(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
